// File: rtl/eth_rx_frame_player.sv
// Programmable Ethernet RX frame source: replays frames from an internal word
// memory under a small descriptor table as an AXI4-Stream master, with
// computed tkeep, optional byte reversal, inter-frame gap, loop and stop.
module eth_rx_frame_player #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int MAX_FRAMES = 8,
    parameter int IDX_WIDTH  = $clog2(MAX_FRAMES),
    parameter int GAP_CYCLES = 4,
    parameter bit BYTE_SWAP  = 1'b1
) (
    input  logic                  eth_clk,
    input  logic                  sys_rst,
    input  logic                  mem_wr_en,
    input  logic [ADDR_WIDTH-1:0] mem_wr_addr,
    input  logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  desc_wr_en,
    input  logic [IDX_WIDTH-1:0]  desc_wr_idx,
    input  logic [ADDR_WIDTH-1:0] desc_wr_start,
    input  logic [15:0]           desc_wr_len,
    input  logic                  desc_wr_err,
    input  logic [IDX_WIDTH:0]    num_frames,
    input  logic                  loop_en,
    input  logic                  start,
    input  logic                  stop,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tuser,
    input  logic                  m_tready,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           frames_sent
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_GAP} state_t;

    // Storage (not reset: contents survive a reset by design)
    logic [DATA_WIDTH-1:0] mem_q        [DEPTH];
    logic [ADDR_WIDTH-1:0] desc_start_q [MAX_FRAMES];
    logic [15:0]           desc_len_q   [MAX_FRAMES];
    logic                  desc_err_q   [MAX_FRAMES];

    state_t                state_q, state_d;
    logic [IDX_WIDTH:0]    num_q, num_d;
    logic                  loop_q, loop_d;
    logic [IDX_WIDTH:0]    idx_q, idx_d;
    logic                  pass_sent_q, pass_sent_d;
    logic                  stop_q, stop_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [16:0]           beats_left_q, beats_left_d;
    logic [15:0]           cur_len_q, cur_len_d;
    logic                  cur_err_q, cur_err_d;
    logic [15:0]           gap_q, gap_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [31:0]           frames_sent_q, frames_sent_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic [KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
    logic                  m_tlast_q, m_tlast_d;
    logic                  m_tuser_q, m_tuser_d;

    // Combinational helpers
    logic [IDX_WIDTH-1:0]  desc_idx;
    logic [ADDR_WIDTH-1:0] d_start;
    logic [15:0]           d_len;
    logic                  d_err;
    logic [16:0]           d_beats;
    logic [IDX_WIDTH:0]    idx_inc;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  finish;
    logic                  load_beat;
    logic                  beat_last;
    logic [15:0]           beat_len;
    logic                  beat_err;

    // Next word address, wrapping at the end of the memory
    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    // Words are stored first-wire-byte in the MSBs; the stream wants it in byte 0
    function automatic logic [DATA_WIDTH-1:0] swap_bytes(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (BYTE_SWAP) r[8*i +: 8] = w[8*(KEEP_WIDTH-1-i) +: 8];
            else           r[8*i +: 8] = w[8*i +: 8];
        end
        return r;
    endfunction

    // Keep mask of the final beat: low (len mod KEEP_WIDTH) bytes, or all when 0
    function automatic logic [KEEP_WIDTH-1:0] last_keep(input logic [15:0] len);
        logic [KEEP_WIDTH-1:0] k;
        int r;
        r = int'(len % 16'(KEEP_WIDTH));
        for (int i = 0; i < KEEP_WIDTH; i++) k[i] = (r == 0) || (i < r);
        return k;
    endfunction

    // Frame memory and descriptor table writes, accepted in any state
    always_ff @(posedge eth_clk) begin
        if (mem_wr_en) mem_q[mem_wr_addr] <= mem_wr_data;
        if (desc_wr_en) begin
            desc_start_q[desc_wr_idx] <= desc_wr_start;
            desc_len_q[desc_wr_idx]   <= desc_wr_len;
            desc_err_q[desc_wr_idx]   <= desc_wr_err;
        end
    end

    // Control and output state registers
    always_ff @(posedge eth_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            num_q         <= '0;
            loop_q        <= 1'b0;
            idx_q         <= '0;
            pass_sent_q   <= 1'b0;
            stop_q        <= 1'b0;
            addr_q        <= '0;
            beats_left_q  <= '0;
            cur_len_q     <= '0;
            cur_err_q     <= 1'b0;
            gap_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frames_sent_q <= '0;
            m_tvalid_q    <= 1'b0;
            m_tdata_q     <= '0;
            m_tkeep_q     <= '0;
            m_tlast_q     <= 1'b0;
            m_tuser_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            loop_q        <= loop_d;
            idx_q         <= idx_d;
            pass_sent_q   <= pass_sent_d;
            stop_q        <= stop_d;
            addr_q        <= addr_d;
            beats_left_q  <= beats_left_d;
            cur_len_q     <= cur_len_d;
            cur_err_q     <= cur_err_d;
            gap_q         <= gap_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            frames_sent_q <= frames_sent_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tdata_q     <= m_tdata_d;
            m_tkeep_q     <= m_tkeep_d;
            m_tlast_q     <= m_tlast_d;
            m_tuser_q     <= m_tuser_d;
        end
    end

    // Playback FSM: next state, beat generation and end-of-playback handling
    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        loop_d        = loop_q;
        idx_d         = idx_q;
        pass_sent_d   = pass_sent_q;
        stop_d        = stop_q;
        addr_d        = addr_q;
        beats_left_d  = beats_left_q;
        cur_len_d     = cur_len_q;
        cur_err_d     = cur_err_q;
        gap_d         = gap_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        frames_sent_d = frames_sent_q;
        m_tvalid_d    = m_tvalid_q;
        m_tdata_d     = m_tdata_q;
        m_tkeep_d     = m_tkeep_q;
        m_tlast_d     = m_tlast_q;
        m_tuser_d     = m_tuser_q;
        finish        = 1'b0;
        load_beat     = 1'b0;
        beat_last     = 1'b0;
        beat_len      = cur_len_q;
        beat_err      = cur_err_q;

        desc_idx = idx_q[IDX_WIDTH-1:0];
        d_start  = desc_start_q[desc_idx];
        d_len    = desc_len_q[desc_idx];
        d_err    = desc_err_q[desc_idx];
        d_beats  = 17'((32'(d_len) + 32'(KEEP_WIDTH - 1)) / 32'(KEEP_WIDTH));
        idx_inc  = idx_q + 1'b1;
        hs       = m_tvalid_q && m_tready;
        // LOAD reads the frame's first word; STREAM reads the next word
        rd_addr  = (state_q == S_LOAD) ? d_start : addr_q;
        rd_word  = mem_q[rd_addr];

        unique case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (start) begin
                    if (num_frames != '0) begin
                        num_d       = num_frames;
                        loop_d      = loop_en;
                        idx_d       = '0;
                        pass_sent_d = 1'b0;
                        busy_d      = 1'b1;
                        state_d     = S_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (stop || stop_q) begin
                    finish = 1'b1;
                end else if (d_len == 16'd0) begin
                    // Empty descriptor: skip it; a pass with nothing sent ends playback
                    if (idx_inc == num_q) begin
                        if (loop_q && pass_sent_q) begin
                            idx_d       = '0;
                            pass_sent_d = 1'b0;
                        end else begin
                            finish = 1'b1;
                        end
                    end else begin
                        idx_d = idx_inc;
                    end
                end else begin
                    load_beat    = 1'b1;
                    beat_last    = (d_beats == 17'd1);
                    beat_len     = d_len;
                    beat_err     = d_err;
                    cur_len_d    = d_len;
                    cur_err_d    = d_err;
                    addr_d       = addr_inc(d_start);
                    beats_left_d = d_beats - 17'd1;
                    pass_sent_d  = 1'b1;
                    state_d      = S_STREAM;
                end
            end
            S_STREAM: begin
                if (stop) stop_d = 1'b1;
                if (hs) begin
                    if (m_tlast_q) begin
                        frames_sent_d = frames_sent_q + 32'd1;
                        m_tvalid_d    = 1'b0;
                        m_tdata_d     = '0;
                        m_tkeep_d     = '0;
                        m_tlast_d     = 1'b0;
                        m_tuser_d     = 1'b0;
                        if (stop || stop_q) begin
                            finish = 1'b1;
                        end else if (idx_inc == num_q && !loop_q) begin
                            finish = 1'b1;
                        end else begin
                            if (idx_inc == num_q) begin
                                idx_d       = '0;
                                pass_sent_d = 1'b0;
                            end else begin
                                idx_d = idx_inc;
                            end
                            if (GAP_CYCLES > 0) begin
                                gap_d   = 16'(GAP_CYCLES - 1);
                                state_d = S_GAP;
                            end else begin
                                state_d = S_LOAD;
                            end
                        end
                    end else begin
                        load_beat    = 1'b1;
                        beat_last    = (beats_left_q == 17'd1);
                        addr_d       = addr_inc(addr_q);
                        beats_left_d = beats_left_q - 17'd1;
                    end
                end
            end
            S_GAP: begin
                if (stop || stop_q) begin
                    finish = 1'b1;
                end else if (gap_q == 16'd0) begin
                    state_d = S_LOAD;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_beat) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = swap_bytes(rd_word);
            m_tkeep_d  = beat_last ? last_keep(beat_len) : '1;
            m_tlast_d  = beat_last;
            m_tuser_d  = beat_last && beat_err;
        end

        if (finish) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stop_d  = 1'b0;
        end
    end

    assign m_tvalid    = m_tvalid_q;
    assign m_tdata     = m_tdata_q;
    assign m_tkeep     = m_tkeep_q;
    assign m_tlast     = m_tlast_q;
    assign m_tuser     = m_tuser_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_sent = frames_sent_q;

endmodule
